m_wb_uart: RTL and testbench

- Wishbone classic slave UART (8N1, fixed baud) for the midgetv iCE40 boards.
- Sits directly downstream of m_midgetv_core on its CYC_O/STB_O/WE_O/ADR_O/DAT_O bus.
- Replaces software bit-banged usartTX/usartRX with a hardware transmitter and receiver.
- Returns read data on the core's DAT_I and produces ACK_I.

---
 rtl/m_wb_uart.sv | 263 ++++++++++++++++++++++++++
 tb/tb_m_wb_uart.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_wb_uart.sv
// Wishbone classic slave UART, 8N1 at CLKDIV clocks per bit; one wait state per access.
// Writes to a full TX holding register are acknowledged and dropped; a new RX byte overwrites an unread one.
module m_wb_uart #(
  parameter int unsigned CLKDIV = 104,
  parameter int unsigned CNTW   = 16
) (
  input  logic        CLK_I,
  input  logic        RST_In,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [CNTW-1:0] BIT_LD  = CNTW'(CLKDIV);
  localparam logic [CNTW-1:0] HALF_LD = CNTW'(CLKDIV / 2);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic            ack_q, ack_d;
  logic [31:0]     dat_o_q, dat_o_d;

  state_t          tx_state_q, tx_state_d;
  logic [CNTW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      tx_hold_q, tx_hold_d;
  logic            txfull_q, txfull_d;
  logic            tx_line_q, tx_line_d;

  logic            rx_sync1_q, rx_sync1_d;
  logic            rx_sync2_q, rx_sync2_d;
  state_t          rx_state_q, rx_state_d;
  logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            acc, rd_data, rd_stat, wr_data, wr_stat;
  logic            tx_active, tx_load;
  logic            rx_deliver, rx_stop_bad, rxs;
  logic [31:0]     status;
  logic            unused_dat;

  assign acc     = CYC_I & STB_I & ~ack_q;
  assign rd_data = acc & ~WE_I & ~ADR_I;
  assign rd_stat = acc & ~WE_I &  ADR_I;
  assign wr_data = acc &  WE_I & ~ADR_I;
  assign wr_stat = acc &  WE_I &  ADR_I;

  assign tx_active = txfull_q | (tx_state_q != S_IDLE);
  assign status    = {27'h0, tx_active, frame_err_q, overrun_q, rx_valid_q, txfull_q};
  assign rxs       = rx_sync2_q;

  assign DAT_O      = dat_o_q;
  assign ACK_O      = ack_q;
  assign uart_tx    = tx_line_q;
  assign irq        = rx_valid_q;
  assign unused_dat = ^DAT_I[31:8];

  always_comb begin
    ack_d   = acc;
    dat_o_d = '0;
    if (rd_data) begin
      dat_o_d = {24'h0, rx_byte_q};
    end else if (rd_stat) begin
      dat_o_d = status;
    end
  end

  // Counters load the full period and expire on the edge that takes them to zero.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    txfull_d   = txfull_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      S_IDLE: tx_load = txfull_q;
      S_START: begin
        if (tx_cnt_q == CNT_ONE) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = BIT_LD;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == CNT_ONE) begin
          tx_cnt_d = BIT_LD;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == CNT_ONE) begin
          if (txfull_q) begin
            tx_load = 1'b1;
          end else begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = '0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Reloading straight out of STOP keeps queued bytes gap-free.
    if (tx_load) begin
      tx_state_d = S_START;
      tx_cnt_d   = BIT_LD;
      tx_shift_d = tx_hold_q;
      tx_line_d  = 1'b0;
      txfull_d   = 1'b0;
    end
    if (wr_data && !txfull_q) begin
      tx_hold_d = DAT_I[7:0];
      txfull_d  = 1'b1;
    end
  end

  always_comb begin
    rx_sync1_d  = uart_rx;
    rx_sync2_d  = rx_sync1_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_deliver  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rxs) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_LD;
        end
      end
      S_START: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d = BIT_LD;
          rx_bit_d = 3'd0;
          rx_state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d   = BIT_LD;
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_deliver  = 1'b1;
          rx_stop_bad = ~rxs;
          rx_state_d  = S_IDLE;
          rx_cnt_d    = '0;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    if (rd_data && !rx_deliver) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (wr_stat) begin
      if (DAT_I[2]) overrun_d = 1'b0;
      if (DAT_I[3]) frame_err_d = 1'b0;
    end
    // A read landing on the delivery edge consumes the old byte; the new one stays pending.
    if (rx_deliver) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_data) overrun_d = 1'b1;
      if (rx_stop_bad) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_In) begin
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      txfull_q    <= 1'b0;
      tx_line_q   <= 1'b1;
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      txfull_q    <= txfull_d;
      tx_line_q   <= tx_line_d;
      rx_sync1_q  <= rx_sync1_d;
      rx_sync2_q  <= rx_sync2_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_m_wb_uart.sv
// Self-checking bench for m_wb_uart at CLKDIV=4: TX line timeline model, RX flag model, random bytes.
module tb_m_wb_uart;
  localparam int CLKDIV = 4;
  localparam int FRAME  = 10 * CLKDIV;
  localparam int LOGN   = 20000;

  logic        CLK_I   = 1'b0;
  logic        RST_In  = 1'b0;
  logic        CYC_I   = 1'b0;
  logic        STB_I   = 1'b0;
  logic        WE_I    = 1'b0;
  logic        ADR_I   = 1'b0;
  logic [31:0] DAT_I   = '0;
  logic        uart_rx = 1'b1;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        uart_tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic txlog [0:LOGN-1];

  // TX model: scheduled frames (first cycle the start bit is visible, byte)
  int         s_start[$];
  logic [7:0] s_byte[$];
  // RX model
  logic [7:0] m_rx_byte   = 8'h00;
  logic       m_rx_valid  = 1'b0;
  logic       m_overrun   = 1'b0;
  logic       m_frame_err = 1'b0;

  m_wb_uart #(.CLKDIV(CLKDIV), .CNTW(16)) dut (
    .CLK_I(CLK_I), .RST_In(RST_In), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc_n <= cyc_n + 1;
  always @(negedge CLK_I) if (cyc_n < LOGN) txlog[cyc_n] = uart_tx;

  function automatic logic exp_tx(input int c);
    logic [7:0] b;
    int slot;
    for (int i = 0; i < s_start.size(); i++) begin
      if (c >= s_start[i] && c < s_start[i] + FRAME) begin
        slot = (c - s_start[i]) / CLKDIV;
        b = s_byte[i];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int tx_mismatch(input int from, input int to, output int first);
    int bad = 0;
    first = -1;
    for (int c = from; c <= to; c++) begin
      if (txlog[c] !== exp_tx(c)) begin
        if (first < 0) first = c;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic logic [31:0] model_status(input int k);
    logic full, active;
    full = (s_start.size() > 0) && (s_start[s_start.size()-1] >= k);
    active = full;
    for (int i = 0; i < s_start.size(); i++)
      if (k - 1 >= s_start[i] && k - 1 < s_start[i] + FRAME) active = 1'b1;
    return {27'h0, active, m_frame_err, m_overrun, m_rx_valid, full};
  endfunction

  task automatic model_tx_write(input int k, input logic [7:0] b);
    int last_s, st;
    if (s_start.size() > 0) begin
      last_s = s_start[s_start.size()-1];
      if (last_s >= k) return;
      st = (k + 1 > last_s + FRAME) ? k + 1 : last_s + FRAME;
    end else begin
      st = k + 1;
    end
    s_start.push_back(st);
    s_byte.push_back(b);
  endtask

  task automatic model_reset();
    s_start.delete();
    s_byte.delete();
    m_rx_byte = 8'h00; m_rx_valid = 1'b0; m_overrun = 1'b0; m_frame_err = 1'b0;
  endtask

  task automatic wb_cycle(input logic we, input logic adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output int acc_cyc);
    bit got = 0;
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wdat;
    rdat = '0;
    acc_cyc = cyc_n;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge CLK_I);
      if (ACK_O === 1'b1) begin
        got = 1;
        rdat = DAT_O;
        acc_cyc = cyc_n;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: ACK_O=%b after 8 cycles, required 1", ACK_O);
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wait_past(input int c);
    while (cyc_n < c + 2) @(negedge CLK_I);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge CLK_I);
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CLKDIV) @(negedge CLK_I);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge CLK_I);
    if (m_rx_valid) m_overrun = 1'b1;
    m_rx_byte = b;
    m_rx_valid = 1'b1;
    if (!stop) m_frame_err = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int k;
    RST_In = 1'b0;
    repeat (3) @(negedge CLK_I);
    model_reset();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ACK_O); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (DAT_O !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", DAT_O); end
    RST_In = 1'b1;
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", r); end
  endtask

  task automatic test_tx();
    logic [31:0] r, e;
    logic [7:0] b;
    int k, k2, bad, first;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      wb_cycle(1'b1, 1'b0, {24'h0, b}, r, k);
      model_tx_write(k, b);
      wb_cycle(1'b0, 1'b1, 32'h0, r, k2);
      e = model_status(k2);
      checks++; if (r !== e) begin errors++; $display("FAIL tx_status_busy: got %h want %h", r, e); end
      wait_past(k + FRAME + 2);
      bad = tx_mismatch(k, k + FRAME + 2, first);
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL tx_frame %h: %0d wrong cycles, first at +%0d got %b want %b",
                 b, bad, first - k, txlog[first], exp_tx(first));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e;
    int k1, k, bad, first;
    wb_cycle(1'b1, 1'b0, 32'h55, r, k1);
    model_tx_write(k1, 8'h55);
    wb_cycle(1'b1, 1'b0, 32'h0F, r, k);
    model_tx_write(k, 8'h0F);
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL b2b_status_full: got %h want %h", r, e); end
    wb_cycle(1'b1, 1'b0, 32'hFF, r, k);
    model_tx_write(k, 8'hFF);
    wait_past(k1 + 2 * FRAME + 20);
    bad = tx_mismatch(k1, k1 + 2 * FRAME + 20, first);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_line: %0d wrong cycles, first at +%0d got %b want %b",
               bad, first - k1, txlog[first], exp_tx(first));
    end
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL b2b_status_end: got %h want %h", r, e); end
  endtask

  task automatic test_rx();
    logic [31:0] r, e;
    logic [7:0] b;
    int k;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      checks++; if (irq !== m_rx_valid) begin errors++; $display("FAIL rx_irq_set: got %b want %b", irq, m_rx_valid); end
      e = {24'h0, m_rx_byte};
      wb_cycle(1'b0, 1'b0, 32'h0, r, k);
      m_rx_valid = 1'b0; m_overrun = 1'b0;
      checks++; if (r !== e) begin errors++; $display("FAIL rx_data: got %h want %h", r, e); end
      wb_cycle(1'b0, 1'b1, 32'h0, r, k);
      e = model_status(k);
      checks++; if (r !== e) begin errors++; $display("FAIL rx_status: got %h want %h", r, e); end
      checks++; if (irq !== m_rx_valid) begin errors++; $display("FAIL rx_irq_clr: got %b want %b", irq, m_rx_valid); end
    end
  endtask

  task automatic test_rx_errors();
    logic [31:0] r, e;
    int k;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL err_overrun_status: got %h want %h", r, e); end
    e = {24'h0, m_rx_byte};
    wb_cycle(1'b0, 1'b0, 32'h0, r, k);
    m_rx_valid = 1'b0; m_overrun = 1'b0;
    checks++; if (r !== e) begin errors++; $display("FAIL err_overrun_data: got %h want %h", r, e); end
    send_rx(8'($urandom_range(0, 255)), 1'b0);
    send_rx(8'($urandom_range(0, 255)), 1'b1);
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL err_frame_status: got %h want %h", r, e); end
    wb_cycle(1'b1, 1'b1, 32'h0C, r, k);
    m_overrun = 1'b0; m_frame_err = 1'b0;
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL err_clear_status: got %h want %h", r, e); end
    e = {24'h0, m_rx_byte};
    wb_cycle(1'b0, 1'b0, 32'h0, r, k);
    m_rx_valid = 1'b0;
    checks++; if (r !== e) begin errors++; $display("FAIL err_last_data: got %h want %h", r, e); end
  endtask

  task automatic test_glitch();
    logic [31:0] r, e;
    int k;
    @(negedge CLK_I);
    uart_rx = 1'b0;
    @(negedge CLK_I);
    uart_rx = 1'b1;
    repeat (FRAME + 10) @(negedge CLK_I);
    checks++; if (irq !== m_rx_valid) begin errors++; $display("FAIL glitch_irq: got %b want %b", irq, m_rx_valid); end
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL glitch_status: got %h want %h", r, e); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r, e;
    logic want;
    int k, rel, bad, first;
    wb_cycle(1'b1, 1'b0, 32'h00, r, k);
    model_tx_write(k, 8'h00);
    while (cyc_n < k + 14) @(negedge CLK_I);
    want = exp_tx(cyc_n);
    checks++; if (uart_tx !== want) begin errors++; $display("FAIL midframe_bit: got %b want %b", uart_tx, want); end
    RST_In = 1'b0;
    @(negedge CLK_I);
    model_reset();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_abort: got %b want 1", uart_tx); end
    @(negedge CLK_I);
    RST_In = 1'b1;
    rel = cyc_n;
    wb_cycle(1'b0, 1'b1, 32'h0, r, k);
    e = model_status(k);
    checks++; if (r !== e) begin errors++; $display("FAIL midframe_status: got %h want %h", r, e); end
    wait_past(rel + FRAME + 5);
    bad = tx_mismatch(rel, rel + FRAME + 5, first);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midframe_idle: %0d wrong cycles, first at +%0d got %b want 1", bad, first - rel, txlog[first]);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_glitch();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
